// File: rtl/prio_index_pkg.sv
// Shared types for the lowest-set-bit index decoder.
// Matches the encoder's {any, idx} beat layout.
package prio_index_pkg;

  localparam int PRIO_WIDTH = 24;
  localparam int PRIO_IDXW  = 5;

  typedef struct packed {
    logic                 any;
    logic [PRIO_IDXW-1:0] idx;
  } prio_code_t;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/prio_onehot_dec.sv
// Combinational {any, idx} to one-hot bit with out-of-range flag.
// Range compare is done one bit wider than idx so it cannot wrap.
module prio_onehot_dec
  import prio_index_pkg::*;
#(
  parameter int WIDTH = PRIO_WIDTH,
  parameter int IDXW  = PRIO_IDXW
) (
  input  logic             i_any,
  input  logic [IDXW-1:0]  i_idx,
  output logic [WIDTH-1:0] o_bit,
  output logic             o_range_err
);

  localparam logic [IDXW:0]    LP_LIMIT = (IDXW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] LP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic w_in_range;

  assign w_in_range  = {1'b0, i_idx} < LP_LIMIT;
  assign o_bit       = (i_any && w_in_range) ? (LP_ONE << i_idx) : '0;
  assign o_range_err = i_any && !w_in_range;

endmodule

// File: rtl/prio_index_decoder.sv
// Rebuilds a WIDTH-bit vector from a stream of {any, idx} beats.
// Optional duplicate detection: define PRIO_INDEX_DECODER_DUP_CHECK_EN.
module prio_index_decoder
  import prio_index_pkg::*;
#(
  parameter int WIDTH = PRIO_WIDTH,
  parameter int IDXW  = PRIO_IDXW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_any,
  input  logic [IDXW-1:0]  in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
`ifdef PRIO_INDEX_DECODER_DUP_CHECK_EN
  output logic             out_dup,
`endif
  output logic             out_err
);

  if (IDXW != $clog2(WIDTH)) begin : g_bad_idxw
    $error("prio_index_decoder: IDXW must equal $clog2(WIDTH)");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prio_index_decoder: WIDTH must be within 2..32");
  end

  dec_state_t       r_state;
  dec_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_vec;
  logic [WIDTH-1:0] w_bit;
  logic             r_err;
  logic             r_out_err;
  logic             w_range_err;
  logic             w_accept;

  prio_onehot_dec #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_dec (
    .i_any       (in_any),
    .i_idx       (in_idx),
    .o_bit       (w_bit),
    .o_range_err (w_range_err)
  );

  assign w_accept = in_valid && in_ready;
  assign out_vec  = r_vec;
  assign out_err  = r_out_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // The last beat's bit bypasses acc straight into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_vec     <= '0;
      r_out_err <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        r_vec     <= r_acc | w_bit;
        r_out_err <= r_err | w_range_err;
        r_acc     <= '0;
        r_err     <= 1'b0;
      end else begin
        r_acc <= r_acc | w_bit;
        r_err <= r_err | w_range_err;
      end
    end
  end

`ifdef PRIO_INDEX_DECODER_DUP_CHECK_EN
  logic r_dup;
  logic r_out_dup;
  logic w_dup_hit;

  assign w_dup_hit = |(r_acc & w_bit);
  assign out_dup   = r_out_dup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dup     <= 1'b0;
      r_out_dup <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        r_out_dup <= r_dup | w_dup_hit;
        r_dup     <= 1'b0;
      end else begin
        r_dup <= r_dup | w_dup_hit;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prio_index_decoder.sv
// Directed bench for prio_index_decoder: vector table,
// backpressure, async reset and encoder loopback sequences.
module tb_prio_index_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_any;
  logic [4:0]  in_idx;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_vec;
  logic        out_err;
`ifdef PRIO_INDEX_DECODER_DUP_CHECK_EN
  logic        out_dup;
`endif

  int n_vec;
  int n_bad;

  prio_index_decoder #(
    .WIDTH (24),
    .IDXW  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_any    (in_any),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
`ifdef PRIO_INDEX_DECODER_DUP_CHECK_EN
    .out_dup   (out_dup),
`endif
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        any;
    bit [4:0]  idx;
    bit        last;
    bit [23:0] evec;
    bit        eerr;
    bit        edup;
  } vec_t;

  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept.
  task automatic send_beat(input bit any, input bit [4:0] idx,
                           input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_any   = any;
    in_idx   = idx;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  bit [23:0] lfsr;
  bit [23:0] w;
  bit        e_any;
  bit [4:0]  e_idx;

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_any    = 1'b0;
    in_idx    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    tbl[0]  = '{1'b1, 5'd5,  1'b1, 24'h000020, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd0,  1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd7,  1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd23, 1'b1, 24'h800081, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd9,  1'b1, 24'h000000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd3,  1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'd25, 1'b1, 24'h000008, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd1,  1'b1, 24'h000002, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd24, 1'b1, 24'h000000, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd9,  1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd9,  1'b1, 24'h000200, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 5'd31, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 5'd0,  1'b1, 24'h000001, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors with out_ready held high
    for (int i = 0; i <= 12; i++) begin
      send_beat(tbl[i].any, tbl[i].idx, tbl[i].last);
      if (tbl[i].last) begin
        chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("tbl%0d_ready0", i), 32'(in_ready), 32'd0);
        chk($sformatf("tbl%0d_vec", i), 32'(out_vec), 32'(tbl[i].evec));
        chk($sformatf("tbl%0d_err", i), 32'(out_err), 32'(tbl[i].eerr));
`ifdef PRIO_INDEX_DECODER_DUP_CHECK_EN
        chk($sformatf("tbl%0d_dup", i), 32'(out_dup), 32'(tbl[i].edup));
`endif
        @(negedge clk);
        chk($sformatf("tbl%0d_ready1", i), 32'(in_ready), 32'd1);
        chk($sformatf("tbl%0d_drop", i), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: output held, pending beat waits in EMIT
    out_ready = 1'b0;
    send_beat(1'b1, 5'd6, 1'b1);
    in_valid = 1'b1;
    in_any   = 1'b1;
    in_idx   = 5'd11;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_vec", 32'(out_vec), 32'h40);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_vec", 32'(out_vec), 32'h800);
    out_ready = 1'b1;
    @(negedge clk);

    // Async reset mid-vector discards acc
    send_beat(1'b1, 5'd2, 1'b0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    send_beat(1'b1, 5'd4, 1'b1);
    chk("rst_mid_vec", 32'(out_vec), 32'h10);
    @(negedge clk);

    // Async reset during EMIT drops out_valid without a clock edge
    out_ready = 1'b0;
    send_beat(1'b1, 5'd1, 1'b1);
    chk("emit_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("emit_rst_valid", 32'(out_valid), 32'd0);
    chk("emit_rst_vec", 32'(out_vec), 32'd0);
    chk("emit_rst_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Loopback through a behavioural encoder on CRC-24 stimulus
    lfsr = 24'hB704CE;
    for (int v = 0; v < 25; v++) begin
      for (int s = 0; s < 8; s++)
        lfsr = lfsr[23] ? ((lfsr << 1) ^ 24'h864CFB) : (lfsr << 1);
      w = (v == 3) ? 24'h0 : lfsr;
      e_any = 1'b0;
      e_idx = '0;
      for (int b = 23; b >= 0; b--)
        if (w[b]) begin
          e_any = 1'b1;
          e_idx = 5'(b);
        end
      send_beat(e_any, e_idx, 1'b1);
      chk($sformatf("loop%0d_vec", v), 32'(out_vec), 32'(w & (~w + 24'd1)));
      chk($sformatf("loop%0d_err", v), 32'(out_err), 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
